sha_msg_schedule: RTL and testbench
===================================

# sha_msg_schedule

SHA-256 message-schedule generator sitting directly upstream of `sha_compressor`. Accepts one 512-bit padded message block over a valid/ready handshake, owns the 6-bit round `counter`, and streams the 64 schedule words W_0..W_63 to the compressor, one per cycle, in the slot alignment the compressor requires. Blocks are accepted back-to-back at one block per 64 cycles.

## Interface
- No parameters. Round count 64 and word width 32 are fixed by SHA-256.
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `blk_valid`  in  1  upstream offers a block
- `blk`  in  512  message block; M_0 in bits 511:480, M_15 in bits 31:0 (big-endian word order)
- `blk_ready`  out  1  block accepted on a cycle with `blk_valid && blk_ready`
- `counter`  out  6  round counter, wired to the compressor's `counter`
- `W`  out  32  schedule word, wired to the compressor's `W`
- `busy`  out  1  a run is in progress (counter != 0 or a run ends this cycle)
- `done`  out  1  one-cycle pulse in the final slot of a run; the compressor's `hash` is valid in this cycle

## Operation
- States: IDLE (counter==0, no run), RUN (counter 1..63, plus the closing counter==0 slot).
- `blk_ready = (counter == 0)`: asserted in IDLE and in the closing slot of a run.
- On accept: 16-word shift register `w[0..15]` loads M_0..M_15; next cycle counter = 1.
- RUN: counter increments by 1 every cycle, wraps 63 -> 0. Holding at a non-zero value is forbidden.
- `W = w[0]` at all times. Each RUN cycle with counter != 0: shift down (w[i] <= w[i+1]), w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], all mod 2^32.
- σ0(x) = rotr7 ^ rotr18 ^ shr3; σ1(x) = rotr17 ^ rotr19 ^ shr10.
- Slot alignment: W_t is presented while counter == (t+1) mod 64. W_0 at counter 1, W_62 at counter 63, W_63 at the closing counter 0.
- Closing slot (counter 0 after 63): `done`=1. If `blk_valid`, next block is loaded, counter -> 1 (no bubble). Else enter IDLE; counter stays 0, shift register holds, W keeps W_63.
- IDLE: counter held at 0 (compressor keeps reloading its input hash state, which is legal).
- The chaining hash presented on the compressor's `inputhashstate` is the integrator's responsibility; this block does not touch hash state.

## Timing
- Reset values: counter=0, all w[i]=0 (so W=0), blk_ready=1, busy=0, done=0, state IDLE.
- Accept-to-W_0 latency: 1 cycle. Accept-to-`done`: 64 cycles.
- Throughput: one block per 64 cycles with `blk_valid` held high.
- `blk` sampled only on the accept edge; it may change at any other time.
- `blk_valid` while counter != 0: ignored (not accepted); upstream must hold it.
- Reset mid-run: counter and shift register clear immediately; no `done`; the partial compressor result is discarded.
- `done` never asserts in IDLE or directly out of reset.

## Structure
- Shared package `sha_pkg`: `Word` (logic[31:0]), `Block` (16 × Word), functions `sigma0`, `sigma1`, constant `ROUNDS = 64`. Reused by the compressor side (Σ functions live alongside).
- One sub-module: `sha_schedule_next`, combinational, inputs w[0], w[1], w[9], w[14], output next word. The remainder (counter, FSM, shift register, handshake) stays in `sha_msg_schedule`.

## Test plan
- Reset then idle 10 cycles -> counter=0, W=0, blk_ready=1, busy=0, done=0 throughout.
- "abc" padded block (M_0=0x61626380, M_1..M_14=0, M_15=0x00000018) -> W=0x61626380 at counter 1, W=0x00000018 at counter 16, W_16=0x61626380 at counter 17, W_17=0x000F0000 at counter 18; all 64 words match software model; done exactly once at accept+64.
- Two blocks with blk_valid held -> second accepted in first's closing slot, counter goes 63,0,1 with no bubble, two done pulses 64 cycles apart.
- blk_valid asserted at counter 30 -> not accepted until closing slot; W stream of first block unchanged.
- rst asserted at counter 40 -> counter=0, W=0, done never pulses; a fresh block then produces a correct stream.
- End-to-end with `sha_compressor` and the IV -> hash at done equals SHA-256("abc") = ba7816bf…f20015ad.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-256 types and bit-mixing functions used by both the message
// schedule and the compressor.
package sha_pkg;

    localparam int ROUNDS = 64;

    typedef logic [31:0] Word;
    // Ascending index so that a raw 512-bit block casts with M_0 landing in element 0.
    typedef Word [0:15] Block;

    typedef enum logic {
        IDLE,
        RUN
    } sched_state_e;

    function automatic Word sigma0(input Word x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic Word sigma1(input Word x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic Word big_sigma0(input Word x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic Word big_sigma1(input Word x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

endpackage

// File: rtl/sha_schedule_next.sv
// Combinational SHA-256 schedule recurrence: the word sixteen slots ahead of w[0].
module sha_schedule_next
    import sha_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w9,
    input  logic [31:0] w14,
    output logic [31:0] next_word
);

    assign next_word = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256 message-schedule generator: loads a padded block and streams W_0..W_63
// to the compressor, W_t aligned to counter == (t+1) mod 64.
module sha_msg_schedule
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    input  logic [511:0] blk,
    output logic         blk_ready,
    output logic [5:0]   counter,
    output logic [31:0]  W,
    output logic         busy,
    output logic         done
);

    sched_state_e state_q, state_d;
    logic [5:0]   counter_q, counter_d;
    Block         w_q, w_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    Word          next_word;
    logic         accept;

    sha_schedule_next u_next (
        .w0        (w_q[0]),
        .w1        (w_q[1]),
        .w9        (w_q[9]),
        .w14       (w_q[14]),
        .next_word (next_word)
    );

    // A block can only be taken while the counter sits at zero: idle or the closing slot.
    assign accept = blk_valid && (counter_q == 6'd0);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        w_d       = w_q;
        if (accept) begin
            state_d   = RUN;
            counter_d = 6'd1;
            w_d       = Block'(blk);
        end else if (counter_q != 6'd0) begin
            state_d   = RUN;
            counter_d = counter_q + 6'd1;
            w_d       = {w_q[1:15], next_word};
        end else begin
            state_d   = IDLE;
        end
        done_d = (state_q == RUN) && (counter_q == 6'(ROUNDS - 1));
        busy_d = (counter_d != 6'd0) || done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= 6'd0;
            w_q       <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            w_q       <= w_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign blk_ready = (counter_q == 6'd0);
    assign counter   = counter_q;
    assign W         = w_q[0];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Self-checking bench for sha_msg_schedule: a software schedule model is compared
// against the DUT on every cycle, plus hand-computed "abc" words and done counts.
module tb_sha_msg_schedule;

    typedef logic [31:0] word_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         blk_valid = 1'b0;
    logic [511:0] blk = '0;
    logic         blk_ready;
    logic [5:0]   counter;
    logic [31:0]  W;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    sha_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk       (blk),
        .blk_ready (blk_ready),
        .counter   (counter),
        .W         (W),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference schedule computed the textbook way: full 64-entry array expansion.
    function automatic word_t ror(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ref_s0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ref_s1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    word_t sched [64];
    int    m_cnt  = 0;
    word_t m_w    = '0;
    logic  m_done = 1'b0;
    logic  cmp_en = 1'b0;
    logic  pin_abc = 1'b0;

    function automatic void expand(input logic [511:0] b);
        for (int t = 0; t < 16; t++) sched[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            sched[t] = ref_s1(sched[t-2]) + sched[t-7] + ref_s0(sched[t-15]) + sched[t-16];
    endfunction

    // Cycle-level expectation: which schedule word should be on W after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  = 0;
            m_w    = '0;
            m_done = 1'b0;
        end else if (m_cnt == 0 && blk_valid) begin
            expand(blk);
            m_cnt  = 1;
            m_w    = sched[0];
            m_done = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt  = (m_cnt + 1) % 64;
            m_w    = sched[(m_cnt + 63) % 64];
            m_done = (m_cnt == 0);
        end else begin
            m_done = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("counter", {26'b0, counter}, 32'(m_cnt));
            checkOutput("W", W, m_w);
            checkOutput("blk_ready", {31'b0, blk_ready}, {31'b0, m_cnt == 0});
            checkOutput("busy", {31'b0, busy}, {31'b0, (m_cnt != 0) || m_done});
            checkOutput("done", {31'b0, done}, {31'b0, m_done});
            if (pin_abc && m_cnt == 1)  checkOutput("abc_W0",  W, 32'h61626380);
            if (pin_abc && m_cnt == 16) checkOutput("abc_W15", W, 32'h00000018);
            if (pin_abc && m_cnt == 17) checkOutput("abc_W16", W, 32'h61626380);
            if (pin_abc && m_cnt == 18) checkOutput("abc_W17", W, 32'h000F0000);
        end
    end

    int  done_seen = 0;
    time done_t[$];

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            done_t.push_back($time);
        end
    end

    task automatic applyStimulus(input logic valid, input logic [511:0] b);
        @(negedge clk);
        #1;
        blk_valid = valid;
        blk       = b;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    logic [511:0] abc_blk;
    logic [511:0] blk_a;
    logic [511:0] blk_b;

    initial begin
        abc_blk = {32'h61626380, 448'b0, 32'h00000018};
        blk_a   = rand_block();
        blk_b   = rand_block();

        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (10) @(posedge clk);
        #1;
        checkOutput("idle_W", W, 32'h0);
        checkOutput("idle_done_count", 32'(done_seen), 32'd0);

        // "abc" block, single run
        pin_abc   = 1'b1;
        done_seen = 0;
        done_t.delete();
        applyStimulus(1'b1, abc_blk);
        @(posedge clk);
        #1 blk_valid = 1'b0;
        repeat (70) @(posedge clk);
        pin_abc = 1'b0;
        checkOutput("abc_done_count", 32'(done_seen), 32'd1);

        // Two blocks back-to-back with blk_valid held
        done_seen = 0;
        done_t.delete();
        applyStimulus(1'b1, blk_a);
        @(posedge clk);
        #1 blk = blk_b;
        repeat (64) @(posedge clk);
        #1 blk_valid = 1'b0;
        blk = rand_block();
        repeat (70) @(posedge clk);
        checkOutput("b2b_done_count", 32'(done_seen), 32'd2);
        if (done_t.size() == 2)
            checkOutput("b2b_done_spacing", 32'((done_t[1] - done_t[0]) / 10), 32'd64);

        // Offer mid-run at counter 30, must wait for the closing slot
        done_seen = 0;
        applyStimulus(1'b1, abc_blk);
        @(posedge clk);
        #1 blk_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        checkOutput("mid_counter", {26'b0, counter}, 32'd30);
        blk_valid = 1'b1;
        blk       = blk_a;
        repeat (35) @(posedge clk);
        #1 blk_valid = 1'b0;
        repeat (70) @(posedge clk);
        checkOutput("mid_done_count", 32'(done_seen), 32'd2);

        // Reset at counter 40, then a fresh block
        done_seen = 0;
        applyStimulus(1'b1, blk_b);
        @(posedge clk);
        #1 blk_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_counter", {26'b0, counter}, 32'd0);
        checkOutput("rst_W", W, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        checkOutput("rst_done_count", 32'(done_seen), 32'd0);
        pin_abc = 1'b1;
        applyStimulus(1'b1, abc_blk);
        @(posedge clk);
        #1 blk_valid = 1'b0;
        repeat (70) @(posedge clk);
        pin_abc = 1'b0;
        checkOutput("post_rst_done_count", 32'(done_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
